// File: rtl/eq_gain_ramp_ctrl.sv
// Gain sequencer: ramps live EQ gains toward CPU targets once per audio frame and
// writes each changed gain into the EQ gain RAM outside the EQ read window.
module eq_gain_ramp_ctrl #(
    parameter int unsigned NUM_FILTERS  = 4,
    parameter int unsigned ADDR_W       = 4,
    parameter logic [15:0] DEFAULT_GAIN = 16'h4000
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              run,
    input  logic              cpu_wr,
    input  logic [ADDR_W-1:0] cpu_sel,
    input  logic [7:0]        cpu_gain_lsb,
    input  logic [7:0]        cpu_gain_msb,
    input  logic [15:0]       ramp_step,
    input  logic              snap,
    input  logic              sample_stb,
    input  logic              eq_busy,
    output logic              eq_wr,
    output logic [ADDR_W-1:0] eq_wr_sel,
    output logic [7:0]        eq_gain_lsb,
    output logic [7:0]        eq_gain_msb,
    output logic              ramp_active,
    output logic              ctrl_busy
);

    typedef enum logic [2:0] {
        S_INIT,
        S_IDLE,
        S_GUARD,
        S_WAIT,
        S_SCAN
    } state_t;

    localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(NUM_FILTERS - 1);

    state_t            state, state_nx;
    logic [ADDR_W-1:0] idx, idx_nx;
    logic [15:0]       tgt [NUM_FILTERS];
    logic [15:0]       cur [NUM_FILTERS];

    logic              snap_pend, frame_pend;
    logic              snap_req, frame_req;
    logic              snap_take, frame_take, snap_load, cur_upd;
    logic              wr_nx;
    logic [ADDR_W-1:0] wr_sel_nx;
    logic [15:0]       wr_data_nx;

    logic [15:0]       cur_i, tgt_i, step_val;
    logic [16:0]       diff, mag;
    logic              any_diff;

    // Operand fetch for the filter under the index pointer
    always_comb begin
        cur_i = '0;
        tgt_i = '0;
        for (int unsigned i = 0; i < NUM_FILTERS; i++) begin
            if (idx == ADDR_W'(i)) begin
                cur_i = cur[i];
                tgt_i = tgt[i];
            end
        end
    end

    // One ramp step; the result always lies between cur and tgt, so no saturation
    always_comb begin
        diff = {tgt_i[15], tgt_i} - {cur_i[15], cur_i};
        mag  = diff[16] ? 17'(-diff) : diff;
        if (ramp_step == '0 || mag <= {1'b0, ramp_step})
            step_val = tgt_i;
        else if (diff[16])
            step_val = cur_i - ramp_step;
        else
            step_val = cur_i + ramp_step;
    end

    always_comb begin
        any_diff = 1'b0;
        for (int unsigned i = 0; i < NUM_FILTERS; i++) begin
            if (cur[i] != tgt[i])
                any_diff = 1'b1;
        end
    end

    assign snap_req  = snap | snap_pend;
    assign frame_req = run & (sample_stb | frame_pend);

    always_ff @(posedge clk) begin
        if (reset)
            state <= S_INIT;
        else
            state <= state_nx;
    end

    always_comb begin
        state_nx   = state;
        idx_nx     = idx;
        wr_nx      = 1'b0;
        wr_sel_nx  = idx;
        wr_data_nx = cur_i;
        cur_upd    = 1'b0;
        snap_load  = 1'b0;
        snap_take  = 1'b0;
        frame_take = 1'b0;
        case (state)
            S_INIT: begin
                if (!eq_busy) begin
                    wr_nx = 1'b1;
                    if (idx == LAST_IDX) begin
                        idx_nx   = '0;
                        state_nx = S_IDLE;
                    end else begin
                        idx_nx = idx + 1'b1;
                    end
                end
            end
            S_IDLE: begin
                if (snap_req) begin
                    snap_take = 1'b1;
                    snap_load = 1'b1;
                    idx_nx    = '0;
                    state_nx  = S_INIT;
                end else if (frame_req) begin
                    frame_take = 1'b1;
                    state_nx   = S_GUARD;
                end
            end
            S_GUARD: state_nx = S_WAIT;
            S_WAIT: begin
                if (!eq_busy) begin
                    idx_nx   = '0;
                    state_nx = S_SCAN;
                end
            end
            S_SCAN: begin
                if (!eq_busy) begin
                    if (step_val != cur_i) begin
                        cur_upd    = 1'b1;
                        wr_nx      = 1'b1;
                        wr_data_nx = step_val;
                    end
                    if (idx == LAST_IDX) begin
                        idx_nx   = '0;
                        state_nx = S_IDLE;
                    end else begin
                        idx_nx = idx + 1'b1;
                    end
                end
            end
            default: state_nx = S_INIT;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            tgt         <= '{default: DEFAULT_GAIN};
            cur         <= '{default: DEFAULT_GAIN};
            idx         <= '0;
            eq_wr       <= 1'b0;
            eq_wr_sel   <= '0;
            eq_gain_lsb <= '0;
            eq_gain_msb <= '0;
            ramp_active <= 1'b0;
            ctrl_busy   <= 1'b1;
            snap_pend   <= 1'b0;
            frame_pend  <= 1'b0;
        end else begin
            for (int unsigned i = 0; i < NUM_FILTERS; i++) begin
                if (cpu_wr && cpu_sel == ADDR_W'(i))
                    tgt[i] <= {cpu_gain_msb, cpu_gain_lsb};
                if (snap_load)
                    cur[i] <= tgt[i];
                else if (cur_upd && idx == ADDR_W'(i))
                    cur[i] <= step_val;
            end
            idx         <= idx_nx;
            eq_wr       <= wr_nx;
            eq_wr_sel   <= wr_sel_nx;
            eq_gain_lsb <= wr_data_nx[7:0];
            eq_gain_msb <= wr_data_nx[15:8];
            ramp_active <= any_diff;
            ctrl_busy   <= (state_nx != S_IDLE);

            if (snap_take)
                snap_pend <= 1'b0;
            else if (snap && state != S_IDLE)
                snap_pend <= 1'b1;

            // A strobe that coincides with a snap in IDLE is kept for after the snap
            if (!run)
                frame_pend <= 1'b0;
            else if (frame_take)
                frame_pend <= 1'b0;
            else if (sample_stb && (state != S_IDLE || snap_take))
                frame_pend <= 1'b1;
        end
    end

endmodule

// File: doc/eq_gain_ramp_ctrl.md
Name: eq_gain_ramp_ctrl

Overview:
- Zipper-free gain sequencer that sits between the CPU gain registers and the EqualizerGains gain RAM write port.
- CPU writes set per-filter target gains. Once per audio frame, the block steps each filter's live gain toward its target by a programmable step.
- Each changed live gain is written into the EQ gain RAM outside the EQ read window, so a gain never changes mid-accumulation.

Parameters:
- NUM_FILTERS, 4, number of EQ filters/gains managed; 1..16.
- ADDR_W, 4, gain RAM address width.
- DEFAULT_GAIN, 16'h4000, reset value of every target and live gain (signed Q1.14, unity).

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- run  in  1  enables per-frame ramping.
- cpu_wr  in  1  strobe: load target gain.
- cpu_sel  in  ADDR_W  target index for cpu_wr.
- cpu_gain_lsb  in  8  target gain [7:0].
- cpu_gain_msb  in  8  target gain [15:8].
- ramp_step  in  16  unsigned step magnitude per frame; 0 = jump to target.
- snap  in  1  strobe: force all live gains to targets and rewrite the RAM.
- sample_stb  in  1  frame strobe (same strobe as the EQ r_data_en).
- eq_busy  in  1  EQ read window active (EQ eq_run).
- eq_wr  out  1  gain RAM write enable.
- eq_wr_sel  out  ADDR_W  gain RAM write address.
- eq_gain_lsb  out  8  gain RAM write data [7:0].
- eq_gain_msb  out  8  gain RAM write data [15:8].
- ramp_active  out  1  any live gain differs from its target.
- ctrl_busy  out  1  FSM not in IDLE.

Behaviour:
- Storage: tgt[NUM_FILTERS] and cur[NUM_FILTERS], both signed 16-bit. All outputs are registered.
- Reset:
  - tgt = cur = DEFAULT_GAIN.
  - eq_wr = 0, eq_wr_sel = 0, eq_gain = 0, ramp_active = 0, ctrl_busy = 1.
  - FSM enters INIT. Reset asserted mid-operation aborts immediately; no further eq_wr is issued that cycle.
- CPU write:
  - cpu_wr loads tgt[cpu_sel] = {msb, lsb} in any state, effective the next cycle.
  - cpu_sel >= NUM_FILTERS is ignored.
  - If cpu_wr targets the index being SCANned in the same cycle, the step uses the old target and the new target applies from the next frame.
- FSM:
  - INIT: writes cur[i] for i = 0..NUM_FILTERS-1, one per cycle (eq_wr = 1), then goes to IDLE. It also pauses while eq_busy = 1.
  - IDLE:
    - snap -> cur = tgt for all filters, then INIT.
    - sample_stb & run -> GUARD.
    - snap has priority over sample_stb.
  - GUARD: one cycle, covering eq_busy rising one cycle after sample_stb. Then WAIT.
  - WAIT: stays while eq_busy = 1. On eq_busy = 0, sets idx = 0 and goes to SCAN.
  - SCAN, one filter per cycle:
    - d = tgt[idx] - cur[idx], computed at 17 bits signed.
    - ramp_step = 0 or |d| <= ramp_step -> new = tgt[idx]; else new = cur[idx] ± ramp_step.
    - No overflow is possible, since the result lies between cur and tgt.
    - If new != cur[idx]: cur[idx] <= new and eq_wr = 1, eq_wr_sel = idx, eq_gain = new on the next cycle. Otherwise eq_wr = 0.
    - Writes occur at scan-start+1 .. scan-start+NUM_FILTERS for idx 0..N-1.
    - After idx = NUM_FILTERS-1 -> IDLE.
- eq_busy rising during SCAN or INIT: hold idx, issue no eq_wr, and resume when eq_busy = 0.
- sample_stb outside IDLE: latched in a one-deep pending flag; serviced on return to IDLE if run = 1. Extra strobes are dropped.
- snap outside IDLE: latched as pending and serviced on return to IDLE before any pending frame.
- run = 0: the current SCAN completes and no new frame starts. Any pending frame is cleared. CPU writes are still captured.
- ramp_active: registered OR over i of (cur[i] != tgt[i]).
- ctrl_busy: 1 in every state except IDLE.

Test Plan:
- Reset, then idle with eq_busy = 0 -> ctrl_busy is 1 for 4 cycles while eq_wr writes addr 0..3 with 16'h4000; afterwards ctrl_busy = 0 and ramp_active = 0.
- cpu_wr sel = 1, gain = 16'h4100, ramp_step = 16'h0040, run = 1, frames with eq_busy high for 4 cycles after each strobe -> writes go only to addr 1, in the order 4040, 4080, 40C0, 4100. ramp_active falls after the 4th frame.
- Target 16'hC000 (negative) on sel 0, ramp_step = 0 -> a single write of C000 to addr 0 on the first frame, issued only after eq_busy has fallen.
- eq_busy forced high for 3 cycles mid-SCAN -> no eq_wr while busy; the index resumes where it stopped and all 4 updates complete.
- snap with tgt = {1000, 2000, 3000, 4000} -> 4 consecutive writes with those values. Then sample_stb during SCAN -> exactly one extra frame runs afterward.
- run dropped mid-SCAN with a pending strobe -> the current scan finishes, the pending strobe is discarded and there are no further writes. Also reset asserted mid-SCAN -> eq_wr = 0 next cycle and INIT rewrites 4000 to all addresses.
